// File: rtl/seg_scan_display.sv
// seg_scan_display: multiplexed hex display driver with a selectable data
// channel.
//
// One of CHANNELS packed data words is captured into a snapshot register.
// The snapshot is scanned out one hex digit at a time, at REFRESH_DIV clocks
// per digit.
//
// Ports:
//   clock     : rising-edge clock
//   reset_n   : asynchronous active-low reset
//   ch_data   : CHANNELS packed words; channel k = [k*DATA_W +: DATA_W]
//   step      : level input; each rising edge advances sel_index
//   hold      : 1 = freeze the snapshot (a new step still captures once)
//   lz_blank  : 1 = blank leading-zero digits (digit 0 is always shown)
//   seg       : active-high segments, seg[0]=a .. seg[6]=g
//   dp        : decimal point, lit on digit 0 while hold=1
//   digit_en  : one-hot active-high digit enable
//   sel_index : currently selected channel
module seg_scan_display #(
  parameter  int DIGITS      = 4,
  parameter  int CHANNELS    = 8,
  parameter  int REFRESH_DIV = 50000,
  localparam int DATA_W      = 4 * DIGITS,
  localparam int SEL_W       = $clog2(CHANNELS)
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [CHANNELS*DATA_W-1:0] ch_data,
  input  logic                       step,
  input  logic                       hold,
  input  logic                       lz_blank,
  output logic [6:0]                 seg,
  output logic                       dp,
  output logic [DIGITS-1:0]          digit_en,
  output logic [SEL_W-1:0]           sel_index
);

  localparam int SCAN_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W  = $clog2(REFRESH_DIV);

  localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(CHANNELS - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(DIGITS - 1);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(REFRESH_DIV - 1);

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic              step_q;
  logic              rise;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              load_pend_q, load_pend_d;
  logic [DATA_W-1:0] snap_q, snap_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [DIGITS-1:0] digit_en_q, digit_en_d;

  logic [3:0]        nibble;
  logic [DIGITS-1:0] upper_zero;
  logic              zero_acc;
  logic              blank;

  always_comb begin
    rise = step & ~step_q;

    sel_d = sel_q;
    if (rise) begin
      sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
    end

    // load_pending lets a step capture the new channel once while holding;
    // the capture uses the already-advanced sel_q on the following edge.
    load_pend_d = rise;

    snap_d = snap_q;
    if (!hold || load_pend_q) begin
      snap_d = ch_data[int'(sel_q)*DATA_W +: DATA_W];
    end

    pre_d  = pre_q;
    scan_d = scan_q;
    if (pre_q == PRE_LAST) begin
      pre_d  = '0;
      scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + SCAN_W'(1);
    end else begin
      pre_d = pre_q + PRE_W'(1);
    end

    // upper_zero[k] = nibbles k..DIGITS-1 of the snapshot are all zero.
    zero_acc   = 1'b1;
    upper_zero = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      zero_acc = zero_acc & (snap_q[(DIGITS-1-i)*4 +: 4] == 4'h0);
      upper_zero[DIGITS-1-i] = zero_acc;
    end

    nibble = snap_q[int'(scan_q)*4 +: 4];
    blank  = lz_blank && (scan_q != '0) && upper_zero[scan_q];

    seg_d = blank ? '0 : hex7(nibble);

    digit_en_d         = '0;
    digit_en_d[scan_q] = 1'b1;

    dp_d = (scan_q == '0) && hold;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      step_q      <= 1'b0;
      sel_q       <= '0;
      load_pend_q <= 1'b0;
      snap_q      <= '0;
      pre_q       <= '0;
      scan_q      <= '0;
      seg_q       <= '0;
      dp_q        <= 1'b0;
      digit_en_q  <= '0;
    end else begin
      step_q      <= step;
      sel_q       <= sel_d;
      load_pend_q <= load_pend_d;
      snap_q      <= snap_d;
      pre_q       <= pre_d;
      scan_q      <= scan_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      digit_en_q  <= digit_en_d;
    end
  end

  assign seg       = seg_q;
  assign dp        = dp_q;
  assign digit_en  = digit_en_q;
  assign sel_index = sel_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed self-checking bench for seg_scan_display with DIGITS=4,
// CHANNELS=8, REFRESH_DIV=4.
module tb_seg_scan_display;

  logic         clk;
  logic         rst_n;
  logic [127:0] ch_data;
  logic         step;
  logic         hold;
  logic         lz_blank;
  logic [6:0]   seg;
  logic         dp;
  logic [3:0]   digit_en;
  logic [2:0]   sel_index;

  int n_cmp = 0;
  int n_err = 0;

  seg_scan_display #(
    .DIGITS      (4),
    .CHANNELS    (8),
    .REFRESH_DIV (4)
  ) dut (
    .clock     (clk),
    .reset_n   (rst_n),
    .ch_data   (ch_data),
    .step      (step),
    .hold      (hold),
    .lz_blank  (lz_blank),
    .seg       (seg),
    .dp        (dp),
    .digit_en  (digit_en),
    .sel_index (sel_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ch(input int k, input logic [15:0] v);
    ch_data[k*16 +: 16] = v;
  endtask

  task automatic step_pulse(input logic [2:0] exp_sel, input string tag);
    step = 1'b1;
    @(negedge clk);
    check(tag, 32'(sel_index), 32'(exp_sel));
    step = 1'b0;
    @(negedge clk);
  endtask

  // Wait (bounded) until digit k is enabled, then check its segments and dp.
  task automatic show_digit(input int k, input logic [6:0] es, input logic edp, input string tag);
    int w;
    logic [3:0] want;
    want = 4'(1 << k);
    w = 0;
    while (digit_en !== want && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20) begin
      check({tag, "_timeout"}, 32'(digit_en), 32'(want));
    end else begin
      check(tag, 32'(seg), 32'(es));
      check({tag, "_dp"}, 32'(dp), 32'(edp));
    end
  endtask

  logic [6:0] seg_1234 [4];

  initial begin
    int slot;
    seg_1234[0] = 7'h66;
    seg_1234[1] = 7'h4F;
    seg_1234[2] = 7'h5B;
    seg_1234[3] = 7'h06;

    rst_n    = 1'b1;
    ch_data  = '0;
    step     = 1'b0;
    hold     = 1'b0;
    lz_blank = 1'b0;
    set_ch(0, 16'h1234);
    #2 rst_n = 1'b0;
    cyc(2);
    check("rst_seg", 32'(seg), 32'h00);
    check("rst_den", 32'(digit_en), 32'h0);
    check("rst_dp", 32'(dp), 32'h0);
    check("rst_sel", 32'(sel_index), 32'h0);

    // Scan sequence after release.
    rst_n = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      @(negedge clk);
      if (n == 1) begin
        check("first_den", 32'(digit_en), 32'h1);
        check("first_seg", 32'(seg), 32'h3F);
      end else begin
        slot = ((n - 1) / 4) % 4;
        check($sformatf("scan_den_%0d", n), 32'(digit_en), 32'(1 << slot));
        check($sformatf("scan_seg_%0d", n), 32'(seg), 32'(seg_1234[slot]));
        check($sformatf("scan_dp_%0d", n), 32'(dp), 32'h0);
      end
    end

    // Leading-zero blanking.
    set_ch(0, 16'h0050);
    lz_blank = 1'b1;
    cyc(3);
    show_digit(3, 7'h00, 1'b0, "lz_d3");
    show_digit(2, 7'h00, 1'b0, "lz_d2");
    show_digit(1, 7'h6D, 1'b0, "lz_d1");
    show_digit(0, 7'h3F, 1'b0, "lz_d0");
    lz_blank = 1'b0;
    cyc(2);
    show_digit(3, 7'h3F, 1'b0, "nolz_d3");
    show_digit(2, 7'h3F, 1'b0, "nolz_d2");
    set_ch(0, 16'h0500);
    lz_blank = 1'b1;
    cyc(3);
    show_digit(3, 7'h00, 1'b0, "lz2_d3");
    show_digit(2, 7'h6D, 1'b0, "lz2_d2");
    show_digit(1, 7'h3F, 1'b0, "lz2_d1");
    set_ch(0, 16'h0000);
    cyc(3);
    show_digit(1, 7'h00, 1'b0, "lz0_d1");
    show_digit(0, 7'h3F, 1'b0, "lz0_d0");
    lz_blank = 1'b0;
    set_ch(0, 16'h1234);
    cyc(3);

    // Hold freezes the snapshot; a step still captures once.
    hold = 1'b1;
    set_ch(0, 16'hFFFF);
    cyc(3);
    show_digit(0, 7'h66, 1'b1, "hold_d0");
    show_digit(1, 7'h4F, 1'b0, "hold_d1");
    show_digit(2, 7'h5B, 1'b0, "hold_d2");
    show_digit(3, 7'h06, 1'b0, "hold_d3");
    set_ch(1, 16'h0007);
    step_pulse(3'd1, "hold_step_sel");
    set_ch(1, 16'h8888);
    cyc(2);
    show_digit(0, 7'h07, 1'b1, "hcap_d0");
    show_digit(1, 7'h3F, 1'b0, "hcap_d1");
    show_digit(2, 7'h3F, 1'b0, "hcap_d2");
    show_digit(3, 7'h3F, 1'b0, "hcap_d3");
    hold = 1'b0;
    cyc(3);
    show_digit(0, 7'h7F, 1'b0, "unhold_d0");

    // Channel stepping to ch3 = ABCD.
    set_ch(3, 16'hABCD);
    step_pulse(3'd2, "step_sel2");
    step_pulse(3'd3, "step_sel3");
    cyc(2);
    show_digit(0, 7'h5E, 1'b0, "ch3_d0");
    show_digit(1, 7'h39, 1'b0, "ch3_d1");
    show_digit(2, 7'h7C, 1'b0, "ch3_d2");
    show_digit(3, 7'h77, 1'b0, "ch3_d3");
    step_pulse(3'd4, "step_sel4");
    step_pulse(3'd5, "step_sel5");

    // Asynchronous reset mid-slot.
    cyc(1);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_seg", 32'(seg), 32'h00);
    check("mrst_den", 32'(digit_en), 32'h0);
    check("mrst_dp", 32'(dp), 32'h0);
    check("mrst_sel", 32'(sel_index), 32'h0);
    cyc(2);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_den", 32'(digit_en), 32'h1);
    check("rel_sel", 32'(sel_index), 32'h0);
    check("rel_seg", 32'(seg), 32'h3F);

    // Step rise on the prescaler wrap edge (4th edge after release).
    cyc(2);
    step = 1'b1;
    @(negedge clk);
    check("wrap_sel", 32'(sel_index), 32'h1);
    check("wrap_den_old", 32'(digit_en), 32'h1);
    @(negedge clk);
    check("wrap_den_new", 32'(digit_en), 32'h2);
    cyc(18);
    check("held_sel", 32'(sel_index), 32'h1);
    step = 1'b0;
    @(negedge clk);
    step_pulse(3'd2, "wr_sel2");
    step_pulse(3'd3, "wr_sel3");
    step_pulse(3'd4, "wr_sel4");
    step_pulse(3'd5, "wr_sel5");
    step_pulse(3'd6, "wr_sel6");
    step_pulse(3'd7, "wr_sel7");
    step_pulse(3'd0, "wr_sel0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
